// File: rtl/io_cell_pullup.sv
// Single FPGA I/O pad cell: input path, output path, tristate control and weak pull-up/down.
// PIN_TYPE[1:0] selects the input mode, PIN_TYPE[5:2] the output mode.
module io_cell_pullup #(
  parameter logic [5:0] PIN_TYPE = 6'b101001,
  parameter logic       PULLUP   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_in,
  input  logic pad_in_valid,
  output logic pad_out,
  output logic pad_oe,
  input  logic clk_en,
  input  logic latch_input_value,
  input  logic d_out_0,
  input  logic output_enable,
  output logic d_in_0,
  output logic contention
);

  typedef enum logic [1:0] {
    IN_REG       = 2'b00,
    IN_SIMPLE    = 2'b01,
    IN_REG_LATCH = 2'b10,
    IN_LATCH     = 2'b11
  } in_mode_e;

  typedef enum logic [3:0] {
    OUT_NONE     = 4'b0000,
    OUT_REG      = 4'b0101,
    OUT_COMB     = 4'b0110,
    OUT_TRI_COMB = 4'b1010,
    OUT_TRI_REG  = 4'b1101
  } out_mode_e;

  localparam logic [1:0] IN_MODE  = PIN_TYPE[1:0];
  localparam logic [3:0] OUT_MODE = PIN_TYPE[5:2];

  logic in_reg;
  logic hold;
  logic out_reg;
  logic oe_reg;
  logic pv;

  // Output path; unlisted encodings fall back to a released pad
  always_comb begin
    pad_oe  = 1'b0;
    pad_out = 1'b0;
    case (OUT_MODE)
      OUT_COMB: begin
        pad_oe  = 1'b1;
        pad_out = d_out_0;
      end
      OUT_REG: begin
        pad_oe  = 1'b1;
        pad_out = out_reg;
      end
      OUT_TRI_COMB: begin
        pad_oe  = output_enable;
        pad_out = d_out_0;
      end
      OUT_TRI_REG: begin
        pad_oe  = oe_reg;
        pad_out = out_reg;
      end
      default: begin
        pad_oe  = 1'b0;
        pad_out = 1'b0;
      end
    endcase
  end

  // Internal driver dominates, then the external driver, then the weak pull
  assign pv         = pad_oe ? pad_out : (pad_in_valid ? pad_in : PULLUP);
  assign contention = pad_oe & pad_in_valid & (pad_in ^ pad_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_reg  <= PULLUP;
      hold    <= PULLUP;
      out_reg <= 1'b0;
      oe_reg  <= 1'b0;
    end else if (clk_en) begin
      out_reg <= d_out_0;
      oe_reg  <= output_enable;
      if (IN_MODE == IN_REG || !latch_input_value)
        in_reg <= pv;
      if (!latch_input_value)
        hold <= pv;
    end
  end

  always_comb begin
    d_in_0 = pv;
    case (IN_MODE)
      IN_SIMPLE:            d_in_0 = pv;
      IN_REG, IN_REG_LATCH: d_in_0 = in_reg;
      IN_LATCH:             d_in_0 = latch_input_value ? hold : pv;
      default:              d_in_0 = pv;
    endcase
  end

endmodule

// File: tb/tb_io_cell_pullup.sv
// Bench for io_cell_pullup: eight configurations share one stimulus and are checked every
// cycle against a behavioural pad model, plus directed checks of the documented scenarios.
module tb_io_cell_pullup;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst, pad_in, pad_in_valid, clk_en, latch_input_value, d_out_0, output_enable;
  logic [N-1:0] pad_out, pad_oe, d_in_0, contention;

  int compared   = 0;
  int mismatched = 0;

  logic [5:0] cfg_pt [N];
  bit         cfg_pu [N];

  // model state: what each cell has captured so far
  bit cap_in [N];
  bit cap_hold [N];
  bit cap_dout [N];
  bit cap_oe [N];

  always #5 clk = ~clk;

  io_cell_pullup #(.PIN_TYPE(6'b101001), .PULLUP(1'b1)) u0 (.clk(clk), .rst(rst), .pad_in(pad_in),
    .pad_in_valid(pad_in_valid), .pad_out(pad_out[0]), .pad_oe(pad_oe[0]), .clk_en(clk_en),
    .latch_input_value(latch_input_value), .d_out_0(d_out_0), .output_enable(output_enable),
    .d_in_0(d_in_0[0]), .contention(contention[0]));
  io_cell_pullup #(.PIN_TYPE(6'b000000), .PULLUP(1'b1)) u1 (.clk(clk), .rst(rst), .pad_in(pad_in),
    .pad_in_valid(pad_in_valid), .pad_out(pad_out[1]), .pad_oe(pad_oe[1]), .clk_en(clk_en),
    .latch_input_value(latch_input_value), .d_out_0(d_out_0), .output_enable(output_enable),
    .d_in_0(d_in_0[1]), .contention(contention[1]));
  io_cell_pullup #(.PIN_TYPE(6'b000011), .PULLUP(1'b0)) u2 (.clk(clk), .rst(rst), .pad_in(pad_in),
    .pad_in_valid(pad_in_valid), .pad_out(pad_out[2]), .pad_oe(pad_oe[2]), .clk_en(clk_en),
    .latch_input_value(latch_input_value), .d_out_0(d_out_0), .output_enable(output_enable),
    .d_in_0(d_in_0[2]), .contention(contention[2]));
  io_cell_pullup #(.PIN_TYPE(6'b110110), .PULLUP(1'b1)) u3 (.clk(clk), .rst(rst), .pad_in(pad_in),
    .pad_in_valid(pad_in_valid), .pad_out(pad_out[3]), .pad_oe(pad_oe[3]), .clk_en(clk_en),
    .latch_input_value(latch_input_value), .d_out_0(d_out_0), .output_enable(output_enable),
    .d_in_0(d_in_0[3]), .contention(contention[3]));
  io_cell_pullup #(.PIN_TYPE(6'b010101), .PULLUP(1'b0)) u4 (.clk(clk), .rst(rst), .pad_in(pad_in),
    .pad_in_valid(pad_in_valid), .pad_out(pad_out[4]), .pad_oe(pad_oe[4]), .clk_en(clk_en),
    .latch_input_value(latch_input_value), .d_out_0(d_out_0), .output_enable(output_enable),
    .d_in_0(d_in_0[4]), .contention(contention[4]));
  io_cell_pullup #(.PIN_TYPE(6'b011000), .PULLUP(1'b1)) u5 (.clk(clk), .rst(rst), .pad_in(pad_in),
    .pad_in_valid(pad_in_valid), .pad_out(pad_out[5]), .pad_oe(pad_oe[5]), .clk_en(clk_en),
    .latch_input_value(latch_input_value), .d_out_0(d_out_0), .output_enable(output_enable),
    .d_in_0(d_in_0[5]), .contention(contention[5]));
  io_cell_pullup #(.PIN_TYPE(6'b111111), .PULLUP(1'b0)) u6 (.clk(clk), .rst(rst), .pad_in(pad_in),
    .pad_in_valid(pad_in_valid), .pad_out(pad_out[6]), .pad_oe(pad_oe[6]), .clk_en(clk_en),
    .latch_input_value(latch_input_value), .d_out_0(d_out_0), .output_enable(output_enable),
    .d_in_0(d_in_0[6]), .contention(contention[6]));
  io_cell_pullup #(.PIN_TYPE(6'b110100), .PULLUP(1'b1)) u7 (.clk(clk), .rst(rst), .pad_in(pad_in),
    .pad_in_valid(pad_in_valid), .pad_out(pad_out[7]), .pad_oe(pad_oe[7]), .clk_en(clk_en),
    .latch_input_value(latch_input_value), .d_out_0(d_out_0), .output_enable(output_enable),
    .d_in_0(d_in_0[7]), .contention(contention[7]));

  // Reference: what the cell drives, how the wire resolves, what the core sees
  function automatic bit m_oe(int i);
    logic [3:0] om = cfg_pt[i][5:2];
    if (om == 4'b0110 || om == 4'b0101) return 1'b1;
    if (om == 4'b1010) return output_enable;
    if (om == 4'b1101) return cap_oe[i];
    return 1'b0;
  endfunction

  function automatic bit m_out(int i);
    logic [3:0] om = cfg_pt[i][5:2];
    if (om == 4'b0110 || om == 4'b1010) return d_out_0;
    if (om == 4'b0101 || om == 4'b1101) return cap_dout[i];
    return 1'b0;
  endfunction

  function automatic bit m_wire(int i);
    if (m_oe(i)) return m_out(i);
    if (pad_in_valid) return pad_in;
    return cfg_pu[i];
  endfunction

  function automatic bit m_din(int i);
    logic [1:0] im = cfg_pt[i][1:0];
    if (im == 2'b01) return m_wire(i);
    if (im == 2'b11) return latch_input_value ? cap_hold[i] : m_wire(i);
    return cap_in[i];
  endfunction

  function automatic bit m_cont(int i);
    return m_oe(i) && pad_in_valid && (pad_in != m_out(i));
  endfunction

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s[u%0d] observed=%b expected=%b t=%0t", tag, idx, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk("d_in_0", i, d_in_0[i], m_din(i));
      chk("pad_oe", i, pad_oe[i], m_oe(i));
      chk("pad_out", i, pad_out[i], m_out(i));
      chk("contention", i, contention[i], m_cont(i));
    end
  endtask

  // Model state advance; all next values use pre-edge state
  task automatic model_edge();
    bit w [N];
    for (int i = 0; i < N; i++) w[i] = m_wire(i);
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        cap_in[i] = cfg_pu[i]; cap_hold[i] = cfg_pu[i];
        cap_dout[i] = 1'b0; cap_oe[i] = 1'b0;
      end else if (clk_en) begin
        cap_dout[i] = d_out_0;
        cap_oe[i]   = output_enable;
        if (!latch_input_value) cap_hold[i] = w[i];
        if (cfg_pt[i][1:0] == 2'b00 || (cfg_pt[i][1:0] == 2'b10 && !latch_input_value))
          cap_in[i] = w[i];
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    cfg_pt[0] = 6'b101001; cfg_pu[0] = 1'b1;
    cfg_pt[1] = 6'b000000; cfg_pu[1] = 1'b1;
    cfg_pt[2] = 6'b000011; cfg_pu[2] = 1'b0;
    cfg_pt[3] = 6'b110110; cfg_pu[3] = 1'b1;
    cfg_pt[4] = 6'b010101; cfg_pu[4] = 1'b0;
    cfg_pt[5] = 6'b011000; cfg_pu[5] = 1'b1;
    cfg_pt[6] = 6'b111111; cfg_pu[6] = 1'b0;
    cfg_pt[7] = 6'b110100; cfg_pu[7] = 1'b1;
    for (int i = 0; i < N; i++) begin
      cap_in[i] = 1'b0; cap_hold[i] = 1'b0; cap_dout[i] = 1'b0; cap_oe[i] = 1'b0;
    end

    rst = 1'b1; pad_in = 1'b0; pad_in_valid = 1'b0; clk_en = 1'b1;
    latch_input_value = 1'b0; d_out_0 = 1'b0; output_enable = 1'b0;
    @(posedge clk); model_edge(); #1;
    tick();
    rst = 1'b0;

    // default config: floating pin reads 1, driven low reads 0 at once
    #1;
    chk("dflt_float_din", 0, d_in_0[0], 1'b1);
    chk("dflt_float_oe", 0, pad_oe[0], 1'b0);
    chk("reg_after_rst", 1, d_in_0[1], 1'b1);
    pad_in_valid = 1'b1; pad_in = 1'b0;
    #1;
    chk("dflt_low_din", 0, d_in_0[0], 1'b0);
    chk("dflt_low_oe", 0, pad_oe[0], 1'b0);

    // registered input: one cycle latency, frozen by clk_en=0
    tick(); tick();
    pad_in = 1'b1;
    #1 chk("reg_before_edge", 1, d_in_0[1], 1'b0);
    tick();
    chk("reg_after_edge", 1, d_in_0[1], 1'b1);
    clk_en = 1'b0; pad_in = 1'b0;
    tick(); tick();
    chk("reg_clk_en_hold", 1, d_in_0[1], 1'b1);
    clk_en = 1'b1;

    // latch input: held value survives pin change
    pad_in = 1'b1;
    tick();
    latch_input_value = 1'b1;
    tick();
    pad_in = 1'b0;
    tick();
    chk("latch_hold", 2, d_in_0[2], 1'b1);
    latch_input_value = 1'b0;
    #1 chk("latch_release", 2, d_in_0[2], 1'b0);

    // contention on the default tristate output
    output_enable = 1'b1; d_out_0 = 1'b0; pad_in_valid = 1'b1; pad_in = 1'b1;
    #1;
    chk("cont_oe", 0, pad_oe[0], 1'b1);
    chk("cont_din", 0, d_in_0[0], 1'b0);
    chk("cont_flag", 0, contention[0], 1'b1);
    output_enable = 1'b0;
    #1;
    chk("nocont_flag", 0, contention[0], 1'b0);
    chk("nocont_din", 0, d_in_0[0], 1'b1);

    // registered tristate: reset releases pad, then one-cycle reappearance
    output_enable = 1'b1; d_out_0 = 1'b1;
    tick(); tick();
    chk("treg_oe_set", 7, pad_oe[7], 1'b1);
    chk("treg_out_set", 7, pad_out[7], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; pad_in_valid = 1'b0;
    #1;
    chk("treg_rst_oe", 7, pad_oe[7], 1'b0);
    chk("treg_rst_out", 7, pad_out[7], 1'b0);
    chk("treg_rst_din", 7, d_in_0[7], 1'b1);
    tick();
    chk("treg_oe_back", 7, pad_oe[7], 1'b1);
    chk("treg_out_back", 7, pad_out[7], 1'b1);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst               = ($urandom_range(0, 29) == 0);
      clk_en            = ($urandom_range(0, 3) != 0);
      pad_in            = 1'($urandom);
      pad_in_valid      = 1'($urandom);
      latch_input_value = ($urandom_range(0, 2) == 0);
      d_out_0           = 1'($urandom);
      output_enable     = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
